// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary helpers for the asynchronous FIFO pointer generators.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    // Both helpers work on 32 bits so callers with any pointer width can zero-extend and truncate.
    function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_gen.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
// Define WPTR_AF_EN to add the registered almost_full output and its fill-level logic.
module wptr_full_gen #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
`ifdef WPTR_AF_EN
    ,
    parameter int unsigned AF_THRESH  = 14
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rq2_wptr_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull
`ifdef WPTR_AF_EN
    ,
    output logic                  almost_full
`endif
);

    import fifo_pkg::*;

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] wptr_q, wgray_d;
    logic [PtrW-1:0] rptr_full_cmp;
    logic            wfull_q, wfull_d;

    assign wen   = winc & ~wfull_q;
    assign waddr = wbin_q[ADDR_WIDTH-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;

    // Full when the next write pointer sits exactly one lap ahead: top two Gray bits inverted.
    assign rptr_full_cmp = {~rq2_wptr_rptr[PtrW-1:PtrW-2], rq2_wptr_rptr[PtrW-3:0]};

    always_comb begin
        wbin_d  = wbin_q + PtrW'(wen);
        wgray_d = PtrW'(bin_to_gray(32'(wbin_d)));
        wfull_d = (wgray_d == rptr_full_cmp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
        end
    end

`ifdef WPTR_AF_EN
    logic [PtrW-1:0] rbin_s;
    logic [PtrW-1:0] level;
    logic            af_q, af_d;

    gray2bin #(
        .WIDTH(PtrW)
    ) u_gray2bin (
        .gray(rq2_wptr_rptr),
        .bin (rbin_s)
    );

    // Modular subtraction gives the true fill level because pointers carry one extra wrap bit.
    always_comb begin
        level = wbin_d - rbin_s;
        af_d  = (level >= PtrW'(AF_THRESH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Scoreboard bench for wptr_full_gen: a count-based FIFO model predicts each cycle's outputs.
module tb_wptr_full_gen;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          winc = 1'b0;
    logic [PW-1:0] rq2_wptr_rptr = '0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
`ifdef WPTR_AF_EN
    logic          almost_full;
`endif

    wptr_full_gen dut (
        .clk          (clk),
        .reset        (reset),
        .winc         (winc),
        .rq2_wptr_rptr(rq2_wptr_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull)
`ifdef WPTR_AF_EN
        ,
        .almost_full  (almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            chk;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [PW-1:0] wptr;
        logic          wfull;
        logic          af;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: unbounded counts of accepted writes and of reads seen through the synchronizer.
    int wr_total = 0;
    int rd_total = 0;
    bit m_full   = 1'b0;
    bit m_af     = 1'b0;
    bit m_known  = 1'b0;

    function automatic logic [PW-1:0] gray_of(input int n);
        int m;
        m = n % (2 * DEPTH);
        return PW'(m ^ (m >> 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One write-clock cycle: apply inputs, queue what the DUT must show this cycle, advance model.
    task automatic cycle(input bit r, input bit w, input int rd);
        exp_t e;
        int   lvl;
        @(posedge clk);
        #1;
        reset         = r;
        winc          = w;
        rd_total      = rd;
        rq2_wptr_rptr = gray_of(rd);
        e.chk   = m_known;
        e.wen   = w && !m_full;
        e.waddr = AW'(wr_total % DEPTH);
        e.wptr  = gray_of(wr_total);
        e.wfull = m_full;
        e.af    = m_af;
        sb.push_back(e);
        if (r) begin
            wr_total = 0;
            m_full   = 1'b0;
            m_af     = 1'b0;
            m_known  = 1'b1;
        end else if (m_known) begin
            if (w && !m_full) wr_total++;
            lvl    = wr_total - rd;
            m_full = (lvl == DEPTH);
            m_af   = (lvl >= AF);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("wen", 32'(wen), 32'(e.wen));
                    check("waddr", 32'(waddr), 32'(e.waddr));
                    check("wptr", 32'(wptr), 32'(e.wptr));
                    check("wfull", 32'(wfull), 32'(e.wfull));
`ifdef WPTR_AF_EN
                    check("almost_full", 32'(almost_full), 32'(e.af));
`endif
                end
            end
        end
    end

    initial begin : stimulus
        int nrd;
        cycle(1, 0, 0);
        // Fill from empty until full, then hammer winc while full.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        // One read frees a slot; one write refills it.
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        // Wrap the pointer with the read side trailing by four.
        for (int i = 0; i < 40; i++) begin
            nrd = (wr_total - 4 > rd_total) ? wr_total - 4 : rd_total;
            cycle(0, 1, nrd);
        end
        // Reset in the middle of a burst.
        cycle(1, 0, rd_total);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        // Random traffic with phases of slow and fast draining.
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit w;
            int adv;
            r   = ($urandom_range(0, 299) == 0);
            w   = ($urandom_range(0, 3) != 0);
            adv = ((i / 100) % 2 == 0) ? int'($urandom_range(0, 3) == 0)
                                       : int'($urandom_range(0, 2));
            nrd = rd_total + adv;
            if (nrd > wr_total) nrd = wr_total;
            cycle(r, w, nrd);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
